sprite_line_prefetch: RTL
=========================

// Module: sprite_line_prefetch
// PURPOSE
// - Scanline sprite prefetcher between the active object RAM / bitmap RAM and the peripheral's RGB output mux.
// - Uses one full display line to walk the sprite table and render a 1-bit hit mask for a future logical row.
// - The mask goes into a double-buffered line buffer; the front bank drives sprite_on during the visible region.
// - Replaces the per-pixel combinational sprite search with a sequential fetch engine.
// PARAMETERS
// - MAX_SPRITES   2    number of 4-byte sprite entries {x, y, bitmap_offset, size}.
// - LINE_PIXELS   160  logical pixels per line (pix_x[9:2]); also the line-buffer width per bank.
// - BITMAP_BYTES  55   valid bitmap RAM bytes; a byte address >= this is transparent.
// - H_ACTIVE      640  pix_x value at which the line_start pulse is generated.
// PORTS
// - clk             in   1   peripheral clock
// - rst_n           in   1   asynchronous active-low reset
// - pix_x           in   10  current pixel column from the video controller
// - pix_y           in   10  current pixel row from the video controller
// - visible         in   1   active video region
// - obj_rd_addr     out  6   object RAM byte address; data is returned 1 cycle later
// - obj_rd_data     in   8   object RAM read data
// - bmp_rd_addr     out  6   bitmap RAM byte address; data is returned 1 cycle later
// - bmp_rd_data     in   8   bitmap RAM read data
// - sprite_on       out  1   registered sprite pixel hit for the current pixel
// - busy            out  1   render FSM not in IDLE
// - overrun         out  1   sticky flag: a render was aborted by line_start
// - overrun_clr     in   1   one-cycle pulse that clears overrun
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0, both banks cleared, front-bank select 0, FSM in IDLE.
// - line_start: internal 1-cycle pulse on the first cycle where pix_x==H_ACTIVE.
// - On line_start (end of line N):
//   - Swap banks.
//   - Clear the new back bank in the same cycle.
//   - Latch target row = (pix_y+2)>>2 as an 8-bit value.
//   - Enter FETCH.
// - FSM IDLE -> FETCH -> CHECK -> DRAW -> NEXT -> (FETCH | IDLE).
//   - FETCH: issue 4 object reads for sprite s; capture the 4 bytes with 1-cycle read latency (5 cycles).
//   - CHECK: width = size[7:4]+1, height = size[3:0]+1.
//     - Row hit iff y <= row < y+height, computed in 9-bit arithmetic with no wrap.
//     - Miss -> NEXT.
//   - DRAW: for c = 0..width-1, 2 cycles per column:
//     - bit_offset = (row-y)*width + c.
//     - byte = bitmap_offset + bit_offset[7:3], 9 bits.
//     - If byte >= BITMAP_BYTES or x+c >= LINE_PIXELS: skip the read and write nothing.
//     - Otherwise read, then set back[x+c] |= bmp_rd_data[bit_offset[2:0]].
//   - NEXT: s+1; after sprite MAX_SPRITES-1 -> IDLE.
// - Sprites OR together; there is no priority ordering.
// - Worst case is 5+1+32+1 = 39 cycles per sprite, well inside one line.
// - line_start while busy:
//   - Abort the current render; the partial back bank is swapped to front as-is.
//   - Set overrun; restart for the new row.
// - If set and clear arrive in the same cycle, the set wins.
// - sprite_on <= visible & front[pix_x[9:2]], 1-cycle latency. It is 0 when pix_x[9:2] >= LINE_PIXELS.
// - Read addresses hold their last value while IDLE.
// CONFIGURATION
// - SPRITE_COLLISION_EN defined:
//   - Adds output `collision` (1 bit, sticky, reset 0) and input `collision_clr`.
//   - collision is set when DRAW writes a 1 to a back-bank bit that is already 1.
//   - Clear behaves like overrun: set wins over a simultaneous clear.
// - SPRITE_COLLISION_EN undefined: no port, no logic; overlapping sprites OR silently.
// TESTING
// - Reset mid-DRAW (rst_n low for 1 cycle) -> busy=0, sprite_on=0, overrun=0; next frame renders correctly.
// - Sprite0 {x=10, y=5, off=0, size=0x33}, bitmap[0..1]=0xFFFF, pix_y=18 at line_start:
//   - Row 5 is rendered for line 20.
//   - On line 20, sprite_on=1 for pix_x 41..56 (latency 1), 0 elsewhere.
// - Sprite {x=158, size=0x30}, row hit:
//   - Logical columns 158..159 are set; 160..161 are clipped.
//   - No out-of-range write; sprite_on=0 for pix_x>=640.
// - bitmap_offset=54, size=0x11, row=y+1 -> byte 54 is read, byte 55 is never addressed (transparent).
// - Force line_start 10 cycles after the previous one -> overrun=1, busy restarts; overrun_clr pulse -> overrun=0.
// - SPRITE_COLLISION_EN: two 2x2 sprites overlapping at (20,20) -> collision=1 after DRAW; disjoint sprites -> 0.

Source files
------------

// File: rtl/sprite_line_prefetch_if.sv
// sprite_line_prefetch_if: object/bitmap RAM read bus; data returns one cycle after the address
interface sprite_line_prefetch_if;
  logic [5:0] obj_rd_addr;
  logic [7:0] obj_rd_data;
  logic [5:0] bmp_rd_addr;
  logic [7:0] bmp_rd_data;
  modport master(output obj_rd_addr, bmp_rd_addr, input obj_rd_data, bmp_rd_data);
  modport slave(input obj_rd_addr, bmp_rd_addr, output obj_rd_data, bmp_rd_data);
endinterface

// File: rtl/sprite_line_prefetch.sv
// sprite_line_prefetch: renders next row's sprite mask into a back line buffer; optional SPRITE_COLLISION_EN
module sprite_line_prefetch #(
  parameter int MAX_SPRITES  = 2,
  parameter int LINE_PIXELS  = 160,
  parameter int BITMAP_BYTES = 55,
  parameter int H_ACTIVE     = 640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       visible,
  sprite_line_prefetch_if.master mem,
  output logic       sprite_on,
  output logic       busy,
  output logic       overrun,
  input  logic       overrun_clr
`ifdef SPRITE_COLLISION_EN
  ,
  output logic       collision,
  input  logic       collision_clr
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, CHECK, DRAW, NEXT} state_t;
  state_t st, st_nx;
  logic at_h, at_h_q, line_start, front_sel, ph, row_hit, col_ok, wr_en, last_col;
  logic [LINE_PIXELS-1:0] bank0, bank1, front;
  logic [7:0] row, spr_x, spr_y, spr_off, spr_size, bit_off, px_l;
  logic [3:0] sidx, col, rel;
  logic [2:0] cnt;
  logic [4:0] width;
  logic [8:0] y_end, byte_addr, xc;
  logic [5:0] obj_hold, bmp_hold;
  assign at_h       = pix_x == 10'(H_ACTIVE);
  assign line_start = at_h & ~at_h_q;
  assign busy       = st != IDLE;
  assign front      = front_sel ? bank1 : bank0;
  assign px_l       = pix_x[9:2];
  assign width      = {1'b0, spr_size[7:4]} + 5'd1;
  assign y_end      = {1'b0, spr_y} + {5'b0, spr_size[3:0]} + 9'd1;
  assign row_hit    = {1'b0, row} >= {1'b0, spr_y} && {1'b0, row} < y_end;
  assign rel        = row[3:0] - spr_y[3:0];
  assign bit_off    = {4'b0, rel} * {3'b0, width} + {4'b0, col};
  assign byte_addr  = {1'b0, spr_off} + {4'b0, bit_off[7:3]};
  assign xc         = {1'b0, spr_x} + {5'b0, col};
  assign col_ok     = byte_addr < 9'(BITMAP_BYTES) && xc < 9'(LINE_PIXELS);
  assign last_col   = {1'b0, col} == width - 5'd1;
  assign wr_en      = st == DRAW && ph && col_ok && mem.bmp_rd_data[bit_off[2:0]] && !line_start;
  assign mem.obj_rd_addr = (st == FETCH && cnt < 3'd4) ? {sidx, cnt[1:0]} : obj_hold;
  assign mem.bmp_rd_addr = (st == DRAW && !ph && col_ok) ? byte_addr[5:0] : bmp_hold;
  // render FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_nx;
  // next state; a new line always restarts the walk from sprite 0
  always_comb begin
    st_nx = st;
    unique case (st)
      FETCH:   st_nx = cnt == 3'd4 ? CHECK : FETCH;
      CHECK:   st_nx = row_hit ? DRAW : NEXT;
      DRAW:    st_nx = ph && last_col ? NEXT : DRAW;
      NEXT:    st_nx = sidx == 4'(MAX_SPRITES - 1) ? IDLE : FETCH;
      default: st_nx = IDLE;
    endcase
    if (line_start) st_nx = FETCH;
  end
  // sprite walk counters, object capture and address hold registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {at_h_q, sidx, cnt, col, ph, row, obj_hold, bmp_hold} <= '0;
      {spr_x, spr_y, spr_off, spr_size} <= '0;
    end else begin
      at_h_q   <= at_h;
      obj_hold <= mem.obj_rd_addr;
      bmp_hold <= mem.bmp_rd_addr;
      if (line_start) begin
        {sidx, cnt, col, ph} <= '0;
        row <= 8'((11'(pix_y) + 11'd2) >> 2);
      end else if (st == FETCH) begin
        cnt <= cnt + 3'd1;
        if (cnt == 3'd1) spr_x <= mem.obj_rd_data;
        if (cnt == 3'd2) spr_y <= mem.obj_rd_data;
        if (cnt == 3'd3) spr_off <= mem.obj_rd_data;
        if (cnt == 3'd4) spr_size <= mem.obj_rd_data;
      end else if (st == DRAW) begin
        ph <= ~ph;
        if (ph) col <= col + 4'd1;
      end else if (st == NEXT) begin
        sidx <= sidx + 4'd1;
        {cnt, col, ph} <= '0;
      end
    end
  // line buffer banks: swap and clear the new back bank on each line start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
      front_sel <= 1'b0;
    end else if (line_start) begin
      front_sel <= ~front_sel;
      if (front_sel) bank1 <= '0;
      else bank0 <= '0;
    end else if (wr_en) begin
      if (front_sel) bank0[xc[7:0]] <= 1'b1;
      else bank1[xc[7:0]] <= 1'b1;
    end
  // pixel output from the front bank and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sprite_on <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sprite_on <= visible && px_l < 8'(LINE_PIXELS) && front[px_l];
      overrun <= (line_start && busy) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
    end
`ifdef SPRITE_COLLISION_EN
  logic back_bit;
  assign back_bit = front_sel ? bank0[xc[7:0]] : bank1[xc[7:0]];
  // sticky collision when a drawn pixel lands on one already set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) collision <= 1'b0;
    else collision <= (wr_en && back_bit) ? 1'b1 : collision_clr ? 1'b0 : collision;
`endif
endmodule
